// File: rtl/spike_weight_fetcher.sv
// spike_weight_fetcher: takes one job (count plus packed synapse indices), reads
// each weight from a synchronous single-port SRAM, streams the weights out over
// valid/ready and reports the per-job weight sum.
module spike_weight_fetcher #(
   parameter int MAX_SPIKE = 128,
   parameter int N_SYNAPSE = 10000,
   parameter int IDX_W     = 14,
   parameter int W_W       = 8,
   parameter int CNT_W     = 8,
   parameter int SIGNED_W  = 0,
   parameter int SUM_W     = W_W + CNT_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [CNT_W-1:0]           num_spike,
   input  logic [IDX_W*MAX_SPIKE-1:0] index_in_flat,
   output logic                       mem_rd_en,
   output logic [IDX_W-1:0]           mem_rd_addr,
   input  logic [W_W-1:0]             mem_rd_data,
   output logic                       w_valid,
   input  logic                       w_ready,
   output logic [W_W-1:0]             w_data,
   output logic [CNT_W-1:0]           w_pos,
   output logic                       w_last,
   output logic                       sum_valid,
   output logic [SUM_W-1:0]           sum_out,
   output logic                       busy,
   output logic                       err_range,
   output logic                       err_count
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam int PW = (MAX_SPIKE > 1) ? $clog2(MAX_SPIKE) : 1;
   localparam logic [CNT_W:0] MAX_C = (CNT_W+1)'(MAX_SPIKE);
   localparam logic [IDX_W:0] N_LIM = (IDX_W+1)'(N_SYNAPSE);

   logic [1:0]       state;
   logic [CNT_W:0]   cnt_q;
   logic [CNT_W:0]   issue_pos;
   logic [IDX_W-1:0] idx_mem [MAX_SPIKE];
   logic [IDX_W-1:0] addr_q;

   // slot issued last cycle; its SRAM data is on mem_rd_data this cycle
   logic             inf_valid;
   logic             inf_oor;
   logic             inf_last;
   logic [CNT_W-1:0] inf_pos;

   logic [W_W-1:0]   f_data [2];
   logic [CNT_W-1:0] f_pos  [2];
   logic             f_last [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       occ;

   logic [SUM_W-1:0] acc;
   logic [SUM_W-1:0] sum_hold;

   logic             accept;
   logic             slot_go;
   logic             slot_last;
   logic             cur_oor;
   logic             pop;
   logic             fifo_pop;
   logic             push;
   logic             sign_bit;
   logic [CNT_W:0]   cnt_eff;
   logic [IDX_W-1:0] cur_idx;
   logic [W_W-1:0]   byp_data;
   logic [SUM_W-1:0] beat_ext;

   assign in_ready  = (state == S_IDLE);
   assign busy      = (state != S_IDLE);
   assign accept    = in_valid && in_ready;
   assign cnt_eff   = ({1'b0, num_spike} > MAX_C) ? MAX_C : {1'b0, num_spike};

   assign cur_idx   = idx_mem[issue_pos[PW-1:0]];
   assign cur_oor   = ({1'b0, cur_idx} >= N_LIM);
   assign slot_go   = (state == S_FETCH) && ((occ + {1'b0, inf_valid}) < 2'd2);
   assign slot_last = (issue_pos == cnt_q - 1'b1);

   // out-of-range slots still occupy the in-flight stage so beat order is kept
   assign mem_rd_en   = slot_go && !cur_oor;
   assign mem_rd_addr = mem_rd_en ? cur_idx : addr_q;

   assign byp_data  = (inf_valid && !inf_oor) ? mem_rd_data : '0;

   // stream head: FIFO entry if any, otherwise the returning SRAM word directly
   always_comb begin
      w_valid = inf_valid;
      w_data  = byp_data;
      w_pos   = inf_pos;
      w_last  = inf_last;
      if (occ != 2'd0) begin
         w_valid = 1'b1;
         w_data  = f_data[rd_ptr];
         w_pos   = f_pos[rd_ptr];
         w_last  = f_last[rd_ptr];
      end
   end

   assign pop      = w_valid && w_ready;
   assign fifo_pop = pop && (occ != 2'd0);
   assign push     = inf_valid && !(pop && (occ == 2'd0));

   assign sign_bit  = (SIGNED_W != 0) && w_data[W_W-1];
   assign beat_ext  = {{(SUM_W-W_W){sign_bit}}, w_data};
   assign sum_valid = (state == S_DONE);
   assign sum_out   = sum_valid ? acc : sum_hold;

   // capture the index list of an accepted job
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int unsigned i = 0; i < MAX_SPIKE; i++) begin
            idx_mem[i] <= index_in_flat[i*IDX_W +: IDX_W];
         end
      end
   end

   // output FIFO storage
   always_ff @(posedge clk) begin
      if (push) begin
         f_data[wr_ptr] <= byp_data;
         f_pos[wr_ptr]  <= inf_pos;
         f_last[wr_ptr] <= inf_last;
      end
   end

   // output FIFO pointers and occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         occ    <= '0;
      end else begin
         if (push)     wr_ptr <= ~wr_ptr;
         if (fifo_pop) rd_ptr <= ~rd_ptr;
         occ <= occ + {1'b0, push} - {1'b0, fifo_pop};
      end
   end

   // job FSM, read issue, accumulator and sticky error flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt_q     <= '0;
         issue_pos <= '0;
         addr_q    <= '0;
         inf_valid <= 1'b0;
         inf_oor   <= 1'b0;
         inf_last  <= 1'b0;
         inf_pos   <= '0;
         acc       <= '0;
         sum_hold  <= '0;
         err_range <= 1'b0;
         err_count <= 1'b0;
      end else begin
         inf_valid <= slot_go;
         if (slot_go) begin
            inf_oor   <= cur_oor;
            inf_pos   <= issue_pos[CNT_W-1:0];
            inf_last  <= slot_last;
            issue_pos <= issue_pos + 1'b1;
            if (cur_oor) err_range <= 1'b1;
         end
         if (mem_rd_en) addr_q <= cur_idx;

         if (accept)   acc <= '0;
         else if (pop) acc <= acc + beat_ext;

         case (state)
            S_IDLE: begin
               if (accept) begin
                  cnt_q     <= cnt_eff;
                  issue_pos <= '0;
                  if ({1'b0, num_spike} > MAX_C) err_count <= 1'b1;
                  state <= (cnt_eff == '0) ? S_DONE : S_FETCH;
               end
            end
            S_FETCH: begin
               if (slot_go && slot_last) state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (pop && w_last) state <= S_DONE;
            end
            default: begin
               sum_hold <= acc;
               state    <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spike_weight_fetcher.sv
// Bench for spike_weight_fetcher: directed jobs with a beat/sum scoreboard,
// an unsigned and a signed instance sharing the same stimulus.
module tb_spike_weight_fetcher;

   localparam int MAX_SPIKE = 128;
   localparam int N_SYN     = 10000;
   localparam int IDX_W     = 14;
   localparam int W_W       = 8;
   localparam int CNT_W     = 8;
   localparam int SUM_W     = 16;
   localparam logic [63:0] RST_VEC = 64'd1 << 53;

   typedef struct packed {
      logic [7:0] d;
      logic [7:0] p;
      logic       l;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid;
   logic w_ready;
   logic [CNT_W-1:0] num_spike;
   logic [IDX_W*MAX_SPIKE-1:0] index_in_flat;

   logic in_ready, mem_rd_en, w_valid, w_last, sum_valid, busy, err_range, err_count;
   logic [IDX_W-1:0] mem_rd_addr;
   logic [W_W-1:0] mem_rd_data = 8'h00;
   logic [W_W-1:0] w_data;
   logic [CNT_W-1:0] w_pos;
   logic [SUM_W-1:0] sum_out;

   logic s_in_ready, s_mem_rd_en, s_w_valid, s_w_last, s_sum_valid, s_busy, s_err_range, s_err_count;
   logic [IDX_W-1:0] s_mem_rd_addr;
   logic [W_W-1:0] s_mem_rd_data = 8'h00;
   logic [W_W-1:0] s_w_data;
   logic [CNT_W-1:0] s_w_pos;
   logic [SUM_W-1:0] s_sum_out;

   spike_weight_fetcher #(.MAX_SPIKE(MAX_SPIKE), .N_SYNAPSE(N_SYN), .IDX_W(IDX_W), .W_W(W_W),
                          .CNT_W(CNT_W), .SIGNED_W(0), .SUM_W(SUM_W)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .num_spike(num_spike),
      .index_in_flat(index_in_flat), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
      .mem_rd_data(mem_rd_data), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
      .w_pos(w_pos), .w_last(w_last), .sum_valid(sum_valid), .sum_out(sum_out), .busy(busy),
      .err_range(err_range), .err_count(err_count));

   spike_weight_fetcher #(.MAX_SPIKE(MAX_SPIKE), .N_SYNAPSE(N_SYN), .IDX_W(IDX_W), .W_W(W_W),
                          .CNT_W(CNT_W), .SIGNED_W(1), .SUM_W(SUM_W)) u_sdut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .num_spike(num_spike),
      .index_in_flat(index_in_flat), .mem_rd_en(s_mem_rd_en), .mem_rd_addr(s_mem_rd_addr),
      .mem_rd_data(s_mem_rd_data), .w_valid(s_w_valid), .w_ready(w_ready), .w_data(s_w_data),
      .w_pos(s_w_pos), .w_last(s_w_last), .sum_valid(s_sum_valid), .sum_out(s_sum_out), .busy(s_busy),
      .err_range(s_err_range), .err_count(s_err_count));

   always #5 clk = ~clk;

   // synapse SRAMs: weight = addr[7:0], one cycle read latency
   always @(posedge clk) begin
      if (mem_rd_en)   mem_rd_data   <= mem_rd_addr[7:0];
      if (s_mem_rd_en) s_mem_rd_data <= s_mem_rd_addr[7:0];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0, n_pass = 0, n_fail = 0;
   beat_t exp_q[$];
   logic [15:0] exp_sum_q[$];
   logic [15:0] exp_ssum, s_sum_seen;
   int n_reads = 0, n_beats = 0, n_sumv = 0, bad_reads = 0;
   int issued = 0, accepted = 0;
   int first_rd = 0, first_wv = 0, last_cyc = 0, sumv_cyc = 0, acc_cyc = 0;
   int sv0, nb0, nr0;
   bit prev_stall = 0;
   logic [16:0] prev_beat;
   beat_t e;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [63:0] rst_vec();
      return 64'({in_ready, mem_rd_en, mem_rd_addr, w_valid, w_data, w_pos, w_last,
                  sum_valid, sum_out, busy, err_range, err_count});
   endfunction

   // monitor: scoreboard pops, stall stability, outstanding-read bound
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 0;
         issued = 0;
         accepted = 0;
      end else begin
         if (mem_rd_en) begin
            n_reads++;
            issued++;
            if (mem_rd_addr == 14'd12000) bad_reads++;
            if (first_rd < 0) first_rd = cyc;
            chk("outstanding_le_2", 64'((issued - accepted) <= 2), 64'd1);
         end
         if (w_valid && first_wv < 0) first_wv = cyc;
         if (prev_stall)
            chk("stall_hold", 64'({w_valid, w_data, w_pos, w_last}), 64'({1'b1, prev_beat}));
         prev_stall = w_valid && !w_ready;
         prev_beat = {w_data, w_pos, w_last};
         if (w_valid && w_ready) begin
            n_beats++;
            accepted++;
            if (w_last) last_cyc = cyc;
            chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk($sformatf("beat%0d_data", e.p), 64'(w_data), 64'(e.d));
               chk($sformatf("beat%0d_pos", e.p), 64'(w_pos), 64'(e.p));
               chk($sformatf("beat%0d_last", e.p), 64'(w_last), 64'(e.l));
            end
         end
         if (sum_valid) begin
            n_sumv++;
            sumv_cyc = cyc;
            chk("sum_expected", 64'(exp_sum_q.size() != 0), 64'd1);
            if (exp_sum_q.size() != 0) chk("sum_out", 64'(sum_out), 64'(exp_sum_q.pop_front()));
         end
         if (s_sum_valid) s_sum_seen = s_sum_out;
      end
   end

   task automatic set_idx(input int i, input int v);
      index_in_flat[i*IDX_W +: IDX_W] = 14'(v);
   endtask

   task automatic offer(input int n);
      int eff, sum, ssum;
      logic [13:0] ix;
      logic [7:0] w;
      beat_t b;
      bit ok;
      eff = (n > MAX_SPIKE) ? MAX_SPIKE : n;
      sum = 0;
      ssum = 0;
      for (int i = 0; i < eff; i++) begin
         ix = index_in_flat[i*IDX_W +: IDX_W];
         w = (int'(ix) >= N_SYN) ? 8'd0 : ix[7:0];
         b.d = w;
         b.p = 8'(i);
         b.l = (i == eff - 1);
         exp_q.push_back(b);
         sum += int'(w);
         ssum += int'($signed(w));
      end
      exp_sum_q.push_back(16'(sum));
      exp_ssum = 16'(ssum);
      sv0 = n_sumv;
      nb0 = n_beats;
      nr0 = n_reads;
      @(negedge clk);
      num_spike = 8'(n);
      in_valid = 1'b1;
      ok = 0;
      for (int t = 0; t < 50; t++) begin
         if (in_ready) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      chk("accept_timeout", 64'(ok), 64'd1);
      acc_cyc = cyc;
      first_rd = -1;
      first_wv = -1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      num_spike = 8'hA5;
      index_in_flat = '1;
   endtask

   task automatic wait_sum(input int mode);
      bit done = 0;
      for (int i = 0; i < 1000; i++) begin
         if (n_sumv != sv0) begin
            done = 1;
            break;
         end
         @(posedge clk);
         #1;
         if (mode == 1) w_ready = ((i % 4) == 0) || ((i % 4) == 3);
         else if (mode == 2) w_ready = 1'($urandom_range(0, 1));
      end
      chk("done_timeout", 64'(done), 64'd1);
      w_ready = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      in_valid = 1'b0;
      w_ready = 1'b1;
      num_spike = '0;
      index_in_flat = '0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", rst_vec(), RST_VEC);
      @(posedge clk);
      #1 rst = 1'b0;

      // 1: basic unsigned job, latency and sum
      set_idx(0, 5); set_idx(1, 9); set_idx(2, 200);
      offer(3);
      wait_sum(0);
      chk("t1_first_rd", 64'(first_rd), 64'(acc_cyc + 1));
      chk("t1_first_wv", 64'(first_wv), 64'(acc_cyc + 2));
      chk("t1_last_beat_cyc", 64'(last_cyc), 64'(acc_cyc + 4));
      chk("t1_sum_valid_cyc", 64'(sumv_cyc), 64'(acc_cyc + 5));
      chk("t1_beats", 64'(n_beats - nb0), 64'd3);
      chk("t1_in_ready", 64'({in_ready, busy}), 64'b10);
      chk("t1_signed_sum", 64'(s_sum_seen), 64'(exp_ssum));

      // 2: same job with 1,0,0,1 backpressure, then random indices and ready
      set_idx(0, 5); set_idx(1, 9); set_idx(2, 200);
      offer(3);
      wait_sum(1);
      chk("t2_beats", 64'(n_beats - nb0), 64'd3);
      chk("t2_queue_empty", 64'(exp_q.size()), 64'd0);
      for (int i = 0; i < 10; i++) set_idx(i, int'($urandom_range(0, N_SYN - 1)));
      offer(10);
      wait_sum(2);
      chk("t2r_beats", 64'(n_beats - nb0), 64'd10);
      chk("t2r_queue_empty", 64'(exp_q.size()), 64'd0);

      // 3: empty job
      offer(0);
      wait_sum(0);
      chk("t3_no_reads", 64'(n_reads - nr0), 64'd0);
      chk("t3_no_beats", 64'(n_beats - nb0), 64'd0);
      chk("t3_sum_latency", 64'((sumv_cyc - acc_cyc) <= 2), 64'd1);
      chk("t3_err_count_clear", 64'(err_count), 64'd0);

      // 4a: oversize count clamps to MAX_SPIKE
      for (int i = 0; i < MAX_SPIKE; i++) set_idx(i, i * 7 + 1);
      offer(200);
      wait_sum(0);
      chk("t4_beats", 64'(n_beats - nb0), 64'(MAX_SPIKE));
      chk("t4_err_count", 64'(err_count), 64'd1);
      chk("t4_err_range_clear", 64'(err_range), 64'd0);

      // 4b: out-of-range index at position 1
      set_idx(0, 7); set_idx(1, 12000); set_idx(2, 40);
      offer(3);
      wait_sum(0);
      chk("t4b_err_range", 64'(err_range), 64'd1);
      chk("t4b_no_bad_read", 64'(bad_reads), 64'd0);
      chk("t4b_reads", 64'(n_reads - nr0), 64'd2);
      chk("t4b_queue_empty", 64'(exp_q.size()), 64'd0);

      // 5: signed weights 0xFF and 0x02
      set_idx(0, 255); set_idx(1, 2);
      offer(2);
      wait_sum(0);
      chk("t5_signed_sum", 64'(s_sum_seen), 64'd1);

      // 6: reset while beat 1 of 4 is stalled
      for (int i = 0; i < 4; i++) set_idx(i, 10 + i);
      offer(4);
      ok = 0;
      for (int t = 0; t < 50; t++) begin
         if (n_beats - nb0 >= 1) begin
            ok = 1;
            break;
         end
         @(posedge clk);
         #1;
      end
      chk("t6_beat0_taken", 64'(ok), 64'd1);
      w_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("t6_stalled_beat1", 64'({w_valid, w_pos}), 64'({1'b1, 8'd1}));
      #2 rst = 1'b1;
      #1 chk("t6_reset_outputs", rst_vec(), RST_VEC);
      exp_q.delete();
      exp_sum_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      w_ready = 1'b1;
      set_idx(0, 20); set_idx(1, 30); set_idx(2, 40);
      offer(3);
      wait_sum(0);
      chk("t6_beats_after", 64'(n_beats - nb0), 64'd3);
      chk("t6_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
